// File: rtl/fir_pkg.sv
// Shared FIR definitions: coefficient loader state encoding.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } fir_state_e;

endpackage

// File: rtl/fir_coeff_loader.sv
// Streams a coefficient frame into a shadow bank and commits it atomically to the
// active bank that feeds the FIR; short or long frames are rejected.
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DELAY = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic [WIDTH-1:0] coeff [0:DELAY-1],
  output logic             coeff_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int IDX_W = $clog2(DELAY);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DELAY - 1);

  fir_state_e       state_r;
  logic [IDX_W-1:0] idx_r;
  logic [WIDTH-1:0] shadow_r [0:DELAY-1];
  logic             hs_s;

  assign hs_s = s_valid & s_ready;

  // Frame FSM with registered handshake/status outputs and the two coefficient banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= {IDX_W{1'b0}};
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      coeff_valid <= 1'b0;
      for (int i = 0; i < DELAY; i++) begin
        shadow_r[i] <= {WIDTH{1'b0}};
        coeff[i]    <= {WIDTH{1'b0}};
      end
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= LOAD;
            idx_r   <= {IDX_W{1'b0}};
            s_ready <= 1'b1;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          if (hs_s) begin
            shadow_r[idx_r] <= s_data;
            if (s_last) begin
              s_ready <= 1'b0;
              if (idx_r == LAST_IDX) begin
                state_r <= COMMIT;
              end else begin
                state_r <= IDLE;
                busy    <= 1'b0;
                err     <= 1'b1;
              end
            end else if (idx_r == LAST_IDX) begin
              // Bank is full but the frame keeps going: swallow the excess, no wrap.
              state_r <= DRAIN;
            end else begin
              idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
          end
        end
        DRAIN: begin
          if (hs_s && s_last) begin
            state_r <= IDLE;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b1;
          end
        end
        COMMIT: begin
          for (int i = 0; i < DELAY; i++) begin
            coeff[i] <= shadow_r[i];
          end
          coeff_valid <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fir_coeff_loader.md
FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 Parameter WIDTH, default 16: coefficient width in bits.
REQ-002 Parameter DELAY, default 8: number of taps; DELAY >= 2.
REQ-003 Reset rst, asynchronous, active-high; clock clk.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  single-cycle request to begin a coefficient frame.
REQ-007 s_valid  in  1  input beat valid.
REQ-008 s_ready  out  1  loader accepts a beat this cycle.
REQ-009 s_data  in  WIDTH  coefficient value, tap 0 first.
REQ-010 s_last  in  1  marks the final beat of a frame.
REQ-011 coeff  out  WIDTH x DELAY (unpacked [0:DELAY-1])  active coefficient bank feeding the FIR coeff input.
REQ-012 coeff_valid  out  1  high once at least one frame has committed since reset.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 done  out  1  one-cycle pulse when a new bank becomes visible on coeff.
REQ-015 err  out  1  one-cycle pulse when a frame is rejected.

Function
REQ-016 The block SHALL implement states IDLE, LOAD, DRAIN and COMMIT.
REQ-017 IDLE: s_ready=0; start=1 moves to LOAD and clears write index idx to 0.
REQ-018 start SHALL be ignored in all states except IDLE.
REQ-019 LOAD: s_ready=1; each handshake (s_valid & s_ready) writes s_data into shadow[idx] and increments idx.
REQ-020 LOAD, handshake with s_last=1 and idx==DELAY-1: move to COMMIT.
REQ-021 LOAD, handshake with s_last=1 and idx<DELAY-1 (short frame): return to IDLE, err pulses the following cycle, active bank unchanged.
REQ-022 LOAD, handshake with s_last=0 and idx==DELAY-1 (long frame): move to DRAIN; idx does not wrap.
REQ-023 DRAIN: s_ready=1, beats discarded; handshake with s_last=1 returns to IDLE with err pulsing the following cycle; active bank unchanged.
REQ-024 COMMIT: lasts exactly one cycle; copies all DELAY shadow entries to the active bank atomically, sets coeff_valid, returns to IDLE.
REQ-025 Latency: final handshake at edge N -> COMMIT during cycle N..N+1 -> new coeff visible and done=1 in cycle after edge N+1; done low otherwise.
REQ-026 coeff SHALL never show a partially written bank; only COMMIT updates it.
REQ-027 s_valid=0 in LOAD/DRAIN SHALL stall without state change; no timeout.
REQ-028 done and err SHALL never be high in the same cycle.
REQ-029 coeff_valid, once set, SHALL remain set until reset; a rejected frame does not clear it.
REQ-030 s_data values are stored bit-exact; no arithmetic or sign interpretation.

Reset
REQ-031 rst (any state, mid-frame included) SHALL force IDLE, idx=0, active and shadow banks all zero, coeff_valid=0, done=0, err=0, busy=0, s_ready=0.
REQ-032 After rst deassertion the first start is honoured on the next rising edge.

Structure
REQ-033 The state enum typedef (IDLE, LOAD, DRAIN, COMMIT) SHALL live in shared package fir_pkg.
REQ-034 WIDTH/DELAY remain module parameters; no constants for them in fir_pkg.
REQ-035 No sub-module; shadow and active banks are flop arrays within fir_coeff_loader.
REQ-036 coeff SHALL connect directly to an FIR coeff input of matching WIDTH and DELAY.

Verification (WIDTH=16, DELAY=4)
REQ-037 Reset then idle 10 cycles -> coeff all 0x0000, coeff_valid=0, s_ready=0, busy=0.
REQ-038 start; beats 0x0001,0x0002,0x0003,0x0004(last), s_valid continuous -> coeff={1,2,3,4}, done one pulse two edges after last beat, coeff_valid=1.
REQ-039 After REQ-038 load, frame 0x0AAA,0x0BBB(last) -> err one pulse, coeff stays {1,2,3,4}, coeff_valid=1, back to IDLE.
REQ-040 Frame of 6 beats 0x0010..0x0015, last on 6th -> DRAIN consumes beats 5-6, err one pulse, coeff unchanged.
REQ-041 Valid frame with s_valid toggling every other cycle plus start pulses mid-frame -> start ignored, coeff={new values} only after done, never partial.
REQ-042 rst asserted after 2 of 4 beats, then a full frame 0x7FFF,0x8000,0xFFFF,0x0000 -> post-reset coeff zero until done, then exactly those four values.
